// File: rtl/section_decision_if.sv
// Operand/result bundle for one FPTD per-bit decision stage.
interface section_decision_if #(
  parameter int N    = 4,
  parameter int M    = 5,
  parameter int P    = 6,
  parameter int ERRW = 8
);
  logic                   Enable;
  logic signed [N-1:0]    bsys;
  logic signed [M-1:0]    be_upper;
  logic signed [M-1:0]    be_lower;
  logic                   Error_upper;
  logic                   Error_lower;
  logic signed [P-1:0]    apost_DFF;
  logic                   b_hat;
  logic                   Stable;
  logic                   Replay;
  logic        [ERRW-1:0] ErrCount;

  modport master (
    output Enable, bsys, be_upper, be_lower, Error_upper, Error_lower,
    input  apost_DFF, b_hat, Stable, Replay, ErrCount
  );

  modport slave (
    input  Enable, bsys, be_upper, be_lower, Error_upper, Error_lower,
    output apost_DFF, b_hat, Stable, Replay, ErrCount
  );
endinterface

// File: rtl/section_decision.sv
// Per-bit decision stage: saturated a-posteriori LLR, hard decision,
// early-stop stability tracking and razor-error replay handling.
module section_decision #(
  parameter int N           = 4,
  parameter int M           = 5,
  parameter int P           = 6,
  parameter int STABLE_ITER = 3,
  parameter int ERRW        = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  nClear,
  section_decision_if.slave     bus
);
  localparam int SW = N + M + 2;
  localparam int CW = $clog2(STABLE_ITER + 1);
  localparam logic signed [SW-1:0] SMAX = SW'((2 ** (P - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN = -SMAX - SW'(1);
  localparam logic        [CW-1:0] CMAX = CW'(STABLE_ITER);

  logic signed [SW-1:0]   sum;
  logic signed [P-1:0]    sat;
  logic                   dec;

  logic signed [P-1:0]    apost_q, apost_n;
  logic                   bhat_q, bhat_n;
  logic                   vld_q, vld_n;
  logic        [CW-1:0]   cnt_q, cnt_n;
  logic                   stable_q, stable_n;
  logic                   rep_q, rep_n;
  logic        [ERRW-1:0] err_q, err_n;

  // Full-width sum, clamp to P bits, strict-positive hard decision
  always_comb begin
    sum = {{(SW-N){bus.bsys[N-1]}}, bus.bsys}
        + {{(SW-M){bus.be_upper[M-1]}}, bus.be_upper}
        + {{(SW-M){bus.be_lower[M-1]}}, bus.be_lower};
    if (sum > SMAX)      sat = SMAX[P-1:0];
    else if (sum < SMIN) sat = SMIN[P-1:0];
    else                 sat = sum[P-1:0];
    dec = !sat[P-1] && (sat != '0);
  end

  // Next state: clear > razor reject > accepted update > hold
  always_comb begin
    apost_n = apost_q;
    bhat_n  = bhat_q;
    vld_n   = vld_q;
    cnt_n   = cnt_q;
    rep_n   = 1'b0;
    err_n   = err_q;
    if (!nClear) begin
      apost_n = '0;
      bhat_n  = 1'b0;
      vld_n   = 1'b0;
      cnt_n   = '0;
      err_n   = '0;
    end else if (bus.Enable && (bus.Error_upper || bus.Error_lower)) begin
      // Rejected iteration: keep decision state, ask upstream to replay
      rep_n = 1'b1;
      if (err_q != '1) err_n = err_q + ERRW'(1);
    end else if (bus.Enable) begin
      apost_n = sat;
      bhat_n  = dec;
      if (!vld_q) begin
        // First update has nothing to compare against
        vld_n = 1'b1;
        cnt_n = '0;
      end else if (dec == bhat_q) begin
        if (cnt_q != CMAX) cnt_n = cnt_q + CW'(1);
      end else begin
        cnt_n = '0;
      end
    end
    stable_n = (cnt_n == CMAX);
  end

  // State registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      apost_q  <= '0;
      bhat_q   <= 1'b0;
      vld_q    <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rep_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      apost_q  <= apost_n;
      bhat_q   <= bhat_n;
      vld_q    <= vld_n;
      cnt_q    <= cnt_n;
      stable_q <= stable_n;
      rep_q    <= rep_n;
      err_q    <= err_n;
    end
  end

  assign bus.apost_DFF = apost_q;
  assign bus.b_hat     = bhat_q;
  assign bus.Stable    = stable_q;
  assign bus.Replay    = rep_q;
  assign bus.ErrCount  = err_q;
endmodule

// File: tb/tb_section_decision.sv
// Vector-table bench for section_decision with an expected-result queue.
module tb_section_decision;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic nClear = 1'b1;

  section_decision_if #(.N(4), .M(5), .P(6), .ERRW(8)) bus ();

  section_decision #(.N(4), .M(5), .P(6), .STABLE_ITER(3), .ERRW(8)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .nClear (nClear),
    .bus    (bus)
  );

  always #10 Clock = ~Clock;

  typedef struct {
    logic nclr, en;
    int   bsys, bu, bl;
    logic eu, el;
    int   apost;
    logic bhat, st, rep;
    int   err;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic nclr, logic en, int bsys, int bu, int bl,
                              logic eu, logic el, int apost, logic bhat,
                              logic st, logic rep, int err);
    vec_t v;
    v.nclr = nclr; v.en = en; v.bsys = bsys; v.bu = bu; v.bl = bl;
    v.eu = eu; v.el = el; v.apost = apost; v.bhat = bhat;
    v.st = st; v.rep = rep; v.err = err;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int apost, logic bhat, logic st,
                         logic rep, int err);
    chk({tag, ".apost"},  int'(bus.apost_DFF), apost);
    chk({tag, ".b_hat"},  int'(bus.b_hat), int'(bhat));
    chk({tag, ".Stable"}, int'(bus.Stable), int'(st));
    chk({tag, ".Replay"}, int'(bus.Replay), int'(rep));
    chk({tag, ".ErrCnt"}, int'(bus.ErrCount), err);
  endtask

  task automatic drive(vec_t v);
    nClear          = v.nclr;
    bus.Enable      = v.en;
    bus.bsys        = 4'(v.bsys);
    bus.be_upper    = 5'(v.bu);
    bus.be_lower    = 5'(v.bl);
    bus.Error_upper = v.eu;
    bus.Error_lower = v.el;
  endtask

  task automatic apply(string tag, vec_t v);
    vec_t e;
    @(negedge Clock);
    drive(v);
    exp_q.push_back(v);
    @(posedge Clock);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk_all(tag, e.apost, e.bhat, e.st, e.rep, e.err);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //            ncl en bsys  bu   bl eu el  apost b st rp err
    vecs.push_back(mk(1, 1,  3,   5,  -2, 0, 0,   6, 1, 0, 0, 0)); // 0 basic
    vecs.push_back(mk(1, 1,  0,   0,   0, 0, 0,   0, 0, 0, 0, 0)); // 1 zero sum
    vecs.push_back(mk(1, 1,  7,  15,  15, 0, 0,  31, 1, 0, 0, 0)); // 2 sat hi
    vecs.push_back(mk(1, 1, -8, -16, -16, 0, 0, -32, 0, 0, 0, 0)); // 3 sat lo
    vecs.push_back(mk(1, 1,  1,   1,   1, 0, 0,   3, 1, 0, 0, 0)); // 4 stab 1
    vecs.push_back(mk(1, 1,  1,   1,   1, 0, 0,   3, 1, 0, 0, 0)); // 5 stab 2
    vecs.push_back(mk(1, 1,  1,   1,   1, 0, 0,   3, 1, 0, 0, 0)); // 6 stab 3
    vecs.push_back(mk(1, 1,  1,   1,   1, 0, 0,   3, 1, 1, 0, 0)); // 7 stab 4
    vecs.push_back(mk(1, 1,  1,   1,   1, 0, 0,   3, 1, 1, 0, 0)); // 8 stab 5
    vecs.push_back(mk(1, 1,  1,  -5,   0, 0, 0,  -4, 0, 0, 0, 0)); // 9 flip
    vecs.push_back(mk(1, 1,  3,   5,  -2, 0, 0,   6, 1, 0, 0, 0)); // 10 prime
    vecs.push_back(mk(1, 1, -2,  -4,  -4, 1, 0,   6, 1, 0, 1, 1)); // 11 reject
    vecs.push_back(mk(1, 1, -2,  -4,  -4, 1, 1,   6, 1, 0, 1, 2)); // 12 both
    vecs.push_back(mk(1, 1, -2,  -4,  -4, 1, 1,   6, 1, 0, 1, 3)); // 13 both
    vecs.push_back(mk(1, 0, -2,  -4,  -4, 0, 0,   6, 1, 0, 0, 3)); // 14 idle
    vecs.push_back(mk(1, 1,  3,   5,  -2, 0, 0,   6, 1, 0, 0, 3)); // 15 cnt1
    vecs.push_back(mk(1, 1,  3,   5,  -2, 0, 0,   6, 1, 0, 0, 3)); // 16 cnt2
    vecs.push_back(mk(1, 1,  3,   5,  -2, 0, 0,   6, 1, 1, 0, 3)); // 17 stable
    vecs.push_back(mk(0, 1,  3,   5,  -2, 1, 0,   0, 0, 0, 0, 0)); // 18 clear
    vecs.push_back(mk(1, 1,  1,   1,   1, 0, 0,   3, 1, 0, 0, 0)); // 19 first
    vecs.push_back(mk(1, 0,  7,   7,   7, 0, 0,   3, 1, 0, 0, 0)); // 20 hold
    vecs.push_back(mk(1, 1,  1,   1,   1, 1, 0,   3, 1, 0, 1, 1)); // 21 reject

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    Reset = 1'b1;
    #25;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge Clock);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    // Quarter-cycle asynchronous reset mid-run with a live update pending
    #1;
    drive(mk(1, 1, 3, 5, -2, 0, 0, 0, 0, 0, 0, 0));
    Reset = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    #4;
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    chk_all("post_rst1", 6, 1, 0, 0, 0);
    apply("post_rst2", mk(1, 1, 3, 5, -2, 0, 0, 6, 1, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/section_decision.md
# section_decision

Per-bit decision stage downstream of a Section_razor1 pair in the fully parallel turbo decoder (FPTD). Each cycle it combines the systematic channel LLR with the extrinsic LLRs produced by the upper-row and lower-row sections. From that sum it produces the registered a-posteriori LLR and the hard bit decision. It also tracks decision stability across iterations so the decoder can stop early. Razor error flags from both feeding sections suppress the update and request a replay.

## Interface
- N, 4, channel LLR width (signed)
- M, 5, extrinsic LLR width (signed)
- P, 6, a-posteriori LLR output width (signed, saturated)
- STABLE_ITER, 3, consecutive unchanged decisions required for Stable
- ERRW, 8, razor error counter width
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- nClear  in  1  synchronous active-low clear of all state
- Enable  in  1  update strobe, one per decoder iteration half
- bsys  in  N  systematic channel LLR (signed)
- be_upper  in  M  be1_DFF from the upper-row section
- be_lower  in  M  be1_DFF from the lower-row section
- Error_upper  in  1  Error_current_be1 from the upper-row section
- Error_lower  in  1  Error_current_be1 from the lower-row section
- apost_DFF  out  P  registered a-posteriori LLR
- b_hat  out  1  registered hard decision
- Stable  out  1  decision unchanged for STABLE_ITER consecutive updates
- Replay  out  1  one-cycle pulse requesting replay of the rejected iteration
- ErrCount  out  ERRW  saturating count of rejected updates

## Operation
- Sum = bsys + be_upper + be_lower.
  - Computed at full width N+M+2 bits with sign extension.
  - Saturated to P bits: range [-2^(P-1), 2^(P-1)-1], which is [-32, 31] at default widths.
- b_hat = 1 iff the saturated sum > 0. A sum of zero gives b_hat = 0.
- Internal state:
  - valid flag
  - previous decision, held in b_hat
  - stable counter, width $clog2(STABLE_ITER+1), saturating at STABLE_ITER
- Priority per edge: Reset (asynchronous) > nClear = 0 > error reject > accepted update > hold.
- Error reject: Enable = 1 and (Error_upper | Error_lower).
  - apost_DFF, b_hat, valid and the counter hold their values.
  - Replay = 1 for one cycle.
  - ErrCount increments by 1, saturating at 2^ERRW-1. Both flags in the same cycle count once.
- Accepted update: Enable = 1, both error flags 0.
  - apost_DFF and b_hat load the new values.
  - If valid = 0: valid becomes 1 and the counter becomes 0.
  - Else, if the new decision equals b_hat: the counter increments, saturating.
  - Else: the counter becomes 0.
  - Replay = 0.
- Enable = 0: all state holds and Replay = 0.
- nClear = 0: clears every register, including ErrCount, valid and the counter, regardless of Enable or the error flags.
- Stable is registered. It equals 1 iff the post-edge counter value is STABLE_ITER.

## Timing
- Reset values are all 0: apost_DFF, b_hat, Stable, Replay, ErrCount, valid and the counter.
- Latency: inputs sampled at edge k appear on apost_DFF and b_hat after edge k.
- Stable: with STABLE_ITER = 3, Stable rises after the 4th consecutive accepted update with the same decision.
  - The 1st accepted update only sets valid.
- Stable falls on the same edge as a decision change or a clear.
- Replay is high for exactly the cycle following each rejected edge.
  - Back-to-back rejects keep Replay high continuously.
  - ErrCount increments on every rejected edge.
- Reset asserted mid-operation: all outputs go to 0 immediately, independent of Clock.
- After Reset deasserts, the first accepted update is treated as the first update (valid = 0).

## Test plan
- Reset: assert Reset for 0.25 cycle mid-run, with Enable = 1 and nonzero inputs. Required: all outputs read 0 before the next edge, and the first update afterwards leaves Stable = 0.
- Basic update: bsys = 3, be_upper = 5, be_lower = -2, Enable = 1. Required: apost_DFF = 6 and b_hat = 1 after one edge.
  - Then bsys = 0, be_upper = 0, be_lower = 0. Required: apost_DFF = 0, b_hat = 0.
- Saturation:
  - bsys = 7, be_upper = 15, be_lower = 15. Required: apost_DFF = 31.
  - bsys = -8, be_upper = -16, be_lower = -16. Required: apost_DFF = -32, b_hat = 0.
- Stability: 5 accepted updates with a positive sum. Required: Stable = 1 after the 4th edge and remains 1 after the 5th.
  - Then a negative-sum update. Required: Stable = 0 and b_hat = 0 after that edge.
- Razor reject: prime with apost_DFF = 6, then Enable = 1, Error_upper = 1, new sum -10. Required: apost_DFF stays 6, Replay = 1 for one cycle, ErrCount = 1.
  - Then Error_upper = Error_lower = 1 for 2 cycles. Required: ErrCount = 3, and Replay stays high for those 2 cycles.
- Clear: after a Stable run with ErrCount = 3, drive nClear = 0 with Enable = 1 and Error_upper = 1. Required: all outputs 0 after the edge, with no Replay pulse.
